// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Helpers work on a 32-bit container; callers zero-extend and truncate to their width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int MAX_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [MAX_WIDTH-1:0] negate(input logic [MAX_WIDTH-1:0] x);
    return ~x + 32'd1;
  endfunction

  // Two's complement magnitude when neg is the operand's sign bit.
  function automatic logic [MAX_WIDTH-1:0] cond_negate(input logic [MAX_WIDTH-1:0] x,
                                                       input logic                 neg);
    return neg ? negate(x) : x;
  endfunction

endpackage

// File: rtl/seq_signed_divider_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor magnitude when it fits.
module div_restore_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;

  // The partial remainder is always below the divisor, so the result fits in WIDTH bits
  // and the subtraction can be done modulo 2^WIDTH.
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {1'b0, dvs_i});
    rem_o   = shifted[WIDTH-1:0] - (q_o ? dvs_i : '0);
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: magnitudes are divided one quotient bit per clock,
// then signs are restored. valid/ready handshakes on both sides.
module seq_signed_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output state_e           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready. in_ready is
  // high exactly in IDLE; out_valid and results hold until the consumer takes them.

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  // dvd_q holds the dividend magnitude and fills with quotient bits from the LSB.
  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    remo_d      = remo_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    dz_d        = dz_q;
    ov_d        = ov_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = WIDTH'(cond_negate(32'(dividend), dividend[WIDTH-1]));
          dvs_d   = WIDTH'(cond_negate(32'(divisor), divisor[WIDTH-1]));
          qsign_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rsign_d = dividend[WIDTH-1];
          dz_d    = (divisor == '0);
          ov_d    = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
          rem_d   = '0;
          cnt_d   = CW'(WIDTH-1);
          state_d = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        dvd_d = {dvd_q[WIDTH-2:0], step_bit};
        rem_d = step_rem;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        if (dz_q) begin
          quot_d = '1;
          remo_d = WIDTH'(cond_negate(32'(dvd_q), rsign_q));
        end else begin
          quot_d = WIDTH'(cond_negate(32'(dvd_q), qsign_q));
          remo_d = WIDTH'(cond_negate(32'(rem_q), rsign_q));
        end
        state_d = DONE;
      end
      DONE: begin
        // out_valid follows the result registers by one clock.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      remo_q      <= '0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      remo_q      <= remo_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and randomised checks for seq_signed_divider at WIDTH=16.
module tb_seq_signed_divider;
  import seq_divider_pkg::*;

  localparam int W = 16;
  localparam int N_RND = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;
  state_e       dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [2*W+1:0] exp_q[$];

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: C-style truncating division on sign-extended operands.
  function automatic logic [2*W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == '0) return {16'hFFFF, a, 1'b1, 1'b0};
    q = sa / sb;
    r = sa % sb;
    return {q[W-1:0], r[W-1:0], 1'b0, (a == 16'h8000 && b == 16'hFFFF)};
  endfunction

  // ---------------- driver tasks (entered #1 after a rising edge) ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("take_valid_low", out_valid, 0);
    check("take_ready_high", in_ready, 1);
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eov, input int elat);
    int n;
    logic saw_ready;
    send(a, b);
    n = 0;
    saw_ready = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) saw_ready = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_busy"}, saw_ready, 0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_flags"}, {div_by_zero, overflow}, {edz, eov});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic saw_valid;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_outputs", {quotient, remainder, out_valid, div_by_zero, overflow}, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, IDLE);

    run_div("pos_pos", 16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 1'b0, 18);
    take();
    run_div("neg_pos", 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18);
    take();
    run_div("pos_neg", 16'd100, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 18);
    take();
    run_div("div_zero", 16'd7, 16'd0, 16'hFFFF, 16'h0007, 1'b1, 1'b0, 2);
    take();
    run_div("ovf", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 18);
    take();

    // Backpressure: result must hold while out_ready is low.
    run_div("bp", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0, 18);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {quotient, remainder, out_valid, in_ready}, {16'd333, 16'd1, 1'b1, 1'b0});
    end
    take();

    // Reset in the middle of a calculation.
    send(16'd500, 16'd9);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_state", dbg_state, CALC);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {quotient, remainder, out_valid, div_by_zero, overflow}, 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    out_ready = 1'b0;
    check("midrst_no_valid", saw_valid, 0);
    run_div("after_rst", 16'd500, 16'd9, 16'd55, 16'd5, 1'b0, 1'b0, 18);
    take();

    // Randomised back-to-back traffic with scoreboard.
    fork
      begin : driver
        logic [W-1:0] a, b;
        int sel, guard;
        for (int i = 0; i < N_RND; i++) begin
          sel = $urandom_range(0, 9);
          a = (sel == 3) ? 16'h8000 : 16'($urandom);
          case (sel)
            0:       b = 16'h0000;
            1, 3:    b = 16'hFFFF;
            2:       b = 16'($urandom_range(1, 15));
            4:       b = 16'(-$urandom_range(1, 15));
            default: b = 16'($urandom);
          endcase
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          in_valid = 1'b1;
          dividend = a;
          divisor  = b;
          guard = 0;
          while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
          end
          if (guard >= 200) begin
            check("rnd_accept_timeout", 1, 0);
            in_valid = 1'b0;
            break;
          end
          @(posedge clk);
          exp_q.push_back(model(a, b));
          #1;
          in_valid = 1'b0;
        end
      end
      begin : monitor
        int got, cycles;
        logic [2*W+1:0] e;
        got = 0;
        cycles = 0;
        while (got < N_RND && cycles < 60000) begin
          @(posedge clk); #1;
          cycles++;
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("rnd_unexpected", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("rnd", {quotient, remainder, div_by_zero, overflow}, e);
            end
            got++;
          end
        end
        if (got < N_RND) check("rnd_timeout", got, N_RND);
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    join
    check("rnd_queue_empty", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
